// File: rtl/icache_direct_mapped_pkg.sv
// Shared types for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;

  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = $clog2(ICACHE_SETS);
  localparam int ITAG_W      = 30 - IIDX_W;

  // Fetch address split for the default geometry.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icache_addr_t;

  // One cache frame for the default geometry.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IC_IDLE  = 1'b0,
    IC_FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage: async read by index, one sync write port, sync valid clear.
module icache_frame_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  // Valid bits: cleared on reset, set by a fill.
  always_ff @(posedge CLK) begin
    if (!nRST)   valid       <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  // Tag/data payload needs no reset; it is qualified by valid.
  always_ff @(posedge CLK) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-block, read-only instruction cache.
// Misses fetch a single word from memory; the access hits the cycle after the fill.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state, next_state;
  logic [29:0]      miss_wa;   // word address of the outstanding miss
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             rvalid;
  logic [TAG_W-1:0] rtag;
  logic [31:0]      rdata;
  logic             hit, miss, fill;
  logic             unused_bytoff;

  assign idx           = imemaddr[IDX_W+1:2];
  assign tag           = imemaddr[31:IDX_W+2];
  assign unused_bytoff = ^imemaddr[1:0];

  assign hit  = (state == IC_IDLE) & imemREN & rvalid & (rtag == tag);
  assign miss = (state == IC_IDLE) & imemREN & ~hit;
  assign fill = (state == IC_FETCH) & ~iwait;

  icache_frame_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .ridx  (idx),
    .rvalid(rvalid),
    .rtag  (rtag),
    .rdata (rdata),
    .we    (fill),
    .widx  (miss_wa[IDX_W-1:0]),
    .wtag  (miss_wa[29:IDX_W]),
    .wdata (iload)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IC_IDLE;
    else       state <= next_state;
  end

  // Next state: a miss starts a fetch; the fetch ends when memory drops iwait.
  always_comb begin
    next_state = state;
    case (state)
      IC_IDLE:  if (miss)   next_state = IC_FETCH;
      IC_FETCH: if (!iwait) next_state = IC_IDLE;
      default:              next_state = IC_IDLE;
    endcase
  end

  // Outputs: hits answer combinationally in IDLE; FETCH drives the memory request.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state)
      IC_IDLE: begin
        ihit     = hit;
        imemload = hit ? rdata : '0;
      end
      IC_FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_wa, 2'b00};
      end
      default: ;
    endcase
  end

  // Capture the miss address so the request is immune to fetch-port changes.
  always_ff @(posedge CLK) begin
    if (!nRST)     miss_wa <= '0;
    else if (miss) miss_wa <= imemaddr[31:2];
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit  && hit_count  != '1) hit_count  <= hit_count  + 1'b1;
      if (miss && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end

endmodule
